// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- definitions shared by the memory pipeline stage.
//   state_e         : FSM state encoding (IDLE / BUSY)
//   DATA_W          : data path width (32)
//   REG_W           : register-index width (5)
//   CNT_W           : countdown counter width (3)
//   DEFAULT_LATENCY : default memory access latency in cycles
package mem_stage_pkg;

  localparam int DATA_W          = 32;
  localparam int REG_W           = 5;
  localparam int CNT_W           = 3;
  localparam int DEFAULT_LATENCY = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_stage_data_sram.sv
// data_sram -- DEPTH x DATA_W single-port synchronous RAM.
// Ports:
//   clk_i   : clock
//   en_i    : access enable (read happens on every enabled edge)
//   we_i    : write enable, qualified by en_i
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : registered read data
// Read-before-write: on an edge that writes addr_i, rdata_o returns the old
// content. The array has no reset, so contents survive a block reset.
module data_sram
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- pipeline memory stage with a fixed multi-cycle memory access.
// Optional feature: define MEM_ALIGN_CHECK_EN to add word-alignment checking
// (misalign_o port; misaligned stores are dropped, misaligned loads read 0).
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   ALU_i             : byte address for memory ops, pass-through otherwise
//   data_i            : store data
//   RD_i              : destination register
//   MemtoReg_i        : load
//   MemWrite_i        : store (wins when both are set)
//   RegWrite_i        : register write enable
//   stall_o           : upstream holds all inputs while high
//   ReadData_o        : load data (0 for non-loads and bubbles)
//   ALU_o, RD_o, MemtoReg_o, RegWrite_o : registered pipeline outputs
//   misalign_o        : registered misalignment flag (MEM_ALIGN_CHECK_EN only)
//
// Handshake: there is no valid/ready pair. An op is accepted in any cycle
// where stall_o is low; while stall_o is high the upstream stage must keep
// every input stable and this stage emits bubbles (all outputs zero).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] ALU_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [REG_W-1:0]  RD_i,
  input  logic              MemtoReg_i,
  input  logic              MemWrite_i,
  input  logic              RegWrite_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] ReadData_o,
  output logic [DATA_W-1:0] ALU_o,
  output logic [REG_W-1:0]  RD_o,
  output logic              MemtoReg_o,
  output logic              RegWrite_o
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misalign_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  // BUSY is entered after the first stall cycle, so it counts LATENCY-2 down to 0.
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  alu_q, alu_d;
  logic [REG_W-1:0]   rd_q, rd_d;
  logic               memtoreg_q, memtoreg_d;
  logic               regwrite_q, regwrite_d;
  logic               load_valid_q, load_valid_d;
  logic               misalign_q, misalign_d;

  logic               mem_op, is_load, misalign, stall, commit, sram_we;
  logic [AW-1:0]      word_idx;
  logic [DATA_W-1:0]  sram_rdata;

  assign word_idx = ALU_i[AW+1:2];

  always_comb begin
    mem_op  = MemtoReg_i | MemWrite_i;
    is_load = MemtoReg_i & ~MemWrite_i;
`ifdef MEM_ALIGN_CHECK_EN
    misalign = mem_op & (ALU_i[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif

    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && (LATENCY > 1)) begin
          stall   = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any non-stalled edge finishes the current op; reset blocks the store.
    commit  = ~stall & mem_op & ~rst_i;
    sram_we = commit & MemWrite_i & ~misalign;

    alu_d        = '0;
    rd_d         = '0;
    memtoreg_d   = 1'b0;
    regwrite_d   = 1'b0;
    load_valid_d = 1'b0;
    misalign_d   = 1'b0;
    if (!stall) begin
      alu_d        = ALU_i;
      rd_d         = RD_i;
      memtoreg_d   = MemtoReg_i;
      regwrite_d   = RegWrite_i;
      load_valid_d = is_load & ~misalign;
      misalign_d   = misalign;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_q        <= '0;
      rd_q         <= '0;
      memtoreg_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_q        <= alu_d;
      rd_q         <= rd_d;
      memtoreg_q   <= memtoreg_d;
      regwrite_q   <= regwrite_d;
      load_valid_q <= load_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  data_sram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_data_sram (
    .clk_i   (clk_i),
    .en_i    (commit),
    .we_i    (sram_we),
    .addr_i  (word_idx),
    .wdata_i (data_i),
    .rdata_o (sram_rdata)
  );

  // The RAM read register only updates on committing edges, so gate it with
  // a flag captured at the same edge to give 0 for anything but a load.
  assign ReadData_o = load_valid_q ? sram_rdata : '0;
  assign stall_o    = stall;
  assign ALU_o      = alu_q;
  assign RD_o       = rd_q;
  assign MemtoReg_o = memtoreg_q;
  assign RegWrite_o = regwrite_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_o = misalign_q;
`endif

  // Address bits outside the word index are intentionally ignored.
  logic unused_alu_bits;
  assign unused_alu_bits = ^{ALU_i[DATA_W-1:AW+2], ALU_i[1:0], misalign_q};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- randomized self-checking bench for mem_stage (LATENCY=3,
// DEPTH=256). Build with MEM_ALIGN_CHECK_EN defined to cover alignment checks.
module tb_mem_stage;

  localparam int DEPTH = 256;
  localparam int LAT   = 3;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_i, data_i;
  logic [4:0]  rd_i;
  logic        m2r_i, mw_i, rw_i;
  logic        stall_o, m2r_o, rw_o;
  logic [31:0] rdata_o, alu_o;
  logic [4:0]  rd_o;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q [$];

  mem_stage #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ALU_i      (alu_i),
    .data_i     (data_i),
    .RD_i       (rd_i),
    .MemtoReg_i (m2r_i),
    .MemWrite_i (mw_i),
    .RegWrite_i (rw_i),
    .stall_o    (stall_o),
    .ReadData_o (rdata_o),
    .ALU_o      (alu_o),
    .RD_o       (rd_o),
    .MemtoReg_o (m2r_o),
    .RegWrite_o (rw_o)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign_o (misalign_o)
`endif
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] data, input logic [4:0] rd,
                       input logic m2r, input logic mw, input logic rw);
    alu_i  = alu;
    data_i = data;
    rd_i   = rd;
    m2r_i  = m2r;
    mw_i   = mw;
    rw_i   = rw;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".alu"}, alu_o, 32'h0);
    check({tag, ".rd"}, 32'(rd_o), 32'h0);
    check({tag, ".m2r"}, 32'(m2r_o), 32'h0);
    check({tag, ".rw"}, 32'(rw_o), 32'h0);
    check({tag, ".rdata"}, rdata_o, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    check({tag, ".misalign"}, 32'(misalign_o), 32'h0);
`endif
  endtask

  // Present one op (called at posedge+1) and follow it to completion against
  // the reference: a memory op takes LAT cycles, the first LAT-1 stalled.
  task automatic run_op(input logic [31:0] alu, input logic [31:0] data, input logic [4:0] rd,
                        input logic m2r, input logic mw, input logic rw);
    int  idx;
    bit  is_mem, is_load, mis;
    int  cycles;
    idx     = int'((alu / 4) % DEPTH);
    is_mem  = m2r || mw;
    is_load = m2r && !mw;
    mis     = ALIGN && is_mem && (alu % 4 != 0);
    cycles  = is_mem ? LAT : 1;
    exp_q.push_back((is_load && !mis) ? model_mem[idx] : 32'h0);
    drive(alu, data, rd, m2r, mw, rw);
    #1;
    for (int i = 0; i < cycles; i++) begin
      check("stall_o", 32'(stall_o), (i < cycles - 1) ? 32'h1 : 32'h0);
      @(posedge clk);
      #1;
      if (i < cycles - 1) begin
        check_zero_outputs("bubble");
      end else begin
        check("ALU_o", alu_o, alu);
        check("RD_o", 32'(rd_o), 32'(rd));
        check("MemtoReg_o", 32'(m2r_o), 32'(m2r));
        check("RegWrite_o", 32'(rw_o), 32'(rw));
        check("ReadData_o", rdata_o, exp_q.pop_front());
`ifdef MEM_ALIGN_CHECK_EN
        check("misalign_o", 32'(misalign_o), 32'(mis));
`endif
      end
    end
    if (mw && !mis) model_mem[idx] = data;
  endtask

  // Start a store and reset it after `hold` edges; the store must not land.
  task automatic reset_during_store(input logic [31:0] alu, input logic [31:0] data, input int hold);
    drive(alu, data, 5'd9, 1'b0, 1'b1, 1'b1);
    #1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
    end
    check("stall_before_rst", 32'(stall_o), (hold < LAT - 1) ? 32'h1 : 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_zero_outputs("after_rst");
    check("stall_after_rst", 32'(stall_o), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero_outputs("reset");
    check("reset.stall", 32'(stall_o), 32'h0);

    // Fill every word so later loads have defined expectations.
    for (int i = 0; i < DEPTH; i++) begin
      run_op(32'(i * 4), $urandom, 5'(i), 1'b0, 1'b1, 1'b0);
    end

    // Non-memory pass-through
    run_op(32'h55, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1);
    // Store then load a known word
    run_op(32'h20, 32'h12345678, 5'd0, 1'b0, 1'b1, 1'b0);
    run_op(32'h20, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1);
    check("load_0x20", rdata_o, 32'h12345678);
    check("load_0x20.rd", 32'(rd_o), 32'd7);
    // Address wrap at DEPTH*4
    run_op(32'h400, 32'hCAFEF00D, 5'd0, 1'b0, 1'b1, 1'b0);
    run_op(32'h000, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1);
    check("wrap_load", rdata_o, 32'hCAFEF00D);
    // Load and store together behaves as a store
    run_op(32'h30, 32'h0BADF00D, 5'd2, 1'b1, 1'b1, 1'b1);
    run_op(32'h30, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1);
    check("both_is_store", rdata_o, 32'h0BADF00D);

    // Reset in the second stall cycle aborts the store
    run_op(32'h40, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
    reset_during_store(32'h40, 32'hA5A5A5A5, 1);
    run_op(32'h40, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1);
    check("aborted_store", rdata_o, 32'h0);
    // Reset on the completing edge wins over the store
    run_op(32'h44, 32'h11111111, 5'd0, 1'b0, 1'b1, 1'b0);
    reset_during_store(32'h44, 32'h22222222, LAT - 1);
    run_op(32'h44, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1);
    check("rst_beats_commit", rdata_o, 32'h11111111);

    // Misaligned store to word 4
    run_op(32'h10, 32'h44444444, 5'd0, 1'b0, 1'b1, 1'b0);
    run_op(32'h13, 32'h99999999, 5'd0, 1'b0, 1'b1, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    run_op(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1);
    check("misaligned_store_dropped", rdata_o, 32'h44444444);
`endif

    // Randomized mix, presented back to back
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      run_op($urandom, $urandom, 5'($urandom_range(0, 31)),
             (kind == 1) || (kind == 3), (kind == 2) || (kind == 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
